seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for a parametrised bank of common-anode/cathode seven-segment digits. Captures a packed hex value into a shadow register on a load strobe. Scans one digit at a time at a programmable refresh rate, with per-digit decimal points, optional leading-zero blanking, a one-clock anti-ghosting gap and selectable output polarities. Sits between the CPU's debug/register-view bus and the board display pins.

## Interface
- DIGITS, 4: number of digits; legal range 1..8.
- REFRESH_DIV, 50000: clocks each digit stays selected; minimum 2.
- BLANK_LZ, 1: 1 = blank leading zero digits.
- SEG_ACTIVE_LOW, 0: 1 = invert seg_out and dp_out at the pins.
- AN_ACTIVE_LOW, 1: 1 = anode bits active-low.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 = least significant).
- dp_in  in  DIGITS  decimal point request per digit.
- load  in  1  capture value and dp_in into the shadow registers.
- enable  in  1  0 = display dark, scan frozen.
- seg_out  out  7  segments {g,f,e,d,c,b,a}.
- dp_out  out  1  decimal point of the selected digit.
- anode  out  DIGITS  one-hot digit select; bit i = digit i.
- digit_idx  out  3  index of the scanned digit, for debug.

## Operation
- Shadow registers sh_val and sh_dp load from value and dp_in on any clock with load=1. Otherwise they hold their value.
- Divider cnt counts 0..REFRESH_DIV-1 while enable=1.
  - At REFRESH_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
  - With enable=0, cnt and idx hold.
- Segment encode, active-high form, as nibble -> {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero blank:
  - Applies only when BLANK_LZ=1.
  - Digit i is blanked (segments 0000000) when i≠0, sh_val nibble i = 0, and every higher nibble = 0.
  - Digit 0 is never blanked.
  - The dp of a blanked digit still follows sh_dp[i].
- Anti-ghost gap: all anode bits are inactive whenever cnt = 0. The previous digit is therefore dark for one clock before the next digit lights.
- Polarity:
  - SEG_ACTIVE_LOW inverts seg_out and dp_out after encoding.
  - AN_ACTIVE_LOW inverts every anode bit.
  - "Inactive" below means the off level after polarity is applied.

## Timing
- All outputs are registered. The outputs at cycle t+1 are a function of cnt, idx, sh_val, sh_dp and enable at cycle t.
- Reset values, immediate and asynchronous:
  - cnt=0, idx=0, sh_val=0, sh_dp=0.
  - anode all inactive; seg_out and dp_out inactive.
  - digit_idx=0.
- Load-to-pin latency is 2 clocks: the shadow register is written at edge 1, and the outputs reflect it at edge 2 if that digit is being scanned.
- A load during a scan takes effect mid-digit without restarting cnt. Glitching of one digit is acceptable.
- Anode pattern with enable held at 1: anode bit idx is active for REFRESH_DIV-1 clocks, then all bits are inactive for 1 clock. The full frame is DIGITS*REFRESH_DIV clocks.
- enable 1->0: one clock later, all anodes, seg_out and dp_out are inactive, and cnt/idx freeze.
- enable 0->1: scanning resumes from the frozen cnt/idx. If the frozen cnt≠0, the digit lights on the next clock.
- Simultaneous load and counter wrap: the new idx and the new shadow data both apply at the following output update.
- Reset asserted mid-scan forces the reset values immediately. After rst_n deasserts, the first active anode is digit 0, one clock after cnt reaches 1.
- When DIGITS=1, idx stays 0 and the gap still occurs once per REFRESH_DIV.

## Test plan
- **Reset:** assert rst_n=0 mid-scan → same cycle: anode=4'b1111 (AN_ACTIVE_LOW=1), seg_out=0000000, digit_idx=0. After release, first lit digit is 0.
- **Full scan:** DIGITS=4, REFRESH_DIV=4, load value=16'h12AF, dp_in=4'b0100, enable=1.
  - Digit 0 → 1110001.
  - Digit 1 → 1110111.
  - Digit 2 → 1011011 with dp_out=1.
  - Digit 3 → 0000110.
  - Each digit is lit 3 clocks followed by a 1-clock all-off gap; frame = 16 clocks.
- **Leading zeros:** load 16'h0050 → digits 3 and 2 show 0000000, digit 1 → 1101101, digit 0 → 0111111. Load 16'h0000 → only digit 0 shows 0111111. Repeat with BLANK_LZ=0 → all four digits show 0111111.
- **Enable:** drop enable mid-digit 2 → next clock all outputs inactive and digit_idx stays 2 for 10 clocks. Raise enable → digit 2 relights on the next clock and completes its remaining count.
- **Load latency/collision:** pulse load with 16'h000F on the exact cycle cnt wraps into digit 0 → digit 0 shows 1110001 at the second edge after the load.
- **Polarity:** SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=0, value nibble 8 → seg_out=0000000 and the active anode bit=1. In the gap, anode=0000 and seg_out=1111111.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a bank of seven-segment digits. A load strobe
//   captures a packed hex value and per-digit decimal points into shadow
//   registers. The scanner lights one digit per refresh period and blanks all
//   anodes for one clock between digits so the previous digit does not ghost.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_value      hex nibbles; nibble i drives digit i (digit 0 = LSD)
//   i_dp_in      decimal point request per digit
//   i_load       capture i_value / i_dp_in into the shadow registers
//   i_enable     0 = display dark and scan frozen
//   o_seg_out    segments {g,f,e,d,c,b,a}, registered, polarity applied
//   o_dp_out     decimal point of the selected digit, registered
//   o_anode      one-hot digit select, registered, polarity applied
//   o_digit_idx  index of the scanned digit (debug)
module seven_seg_scanner #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp_in,
  input  logic                  i_load,
  input  logic                  i_enable,
  output logic [6:0]            o_seg_out,
  output logic                  o_dp_out,
  output logic [DIGITS-1:0]     o_anode,
  output logic [2:0]            o_digit_idx
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [4*DIGITS-1:0]  r_sh_val;
  logic [DIGITS-1:0]    r_sh_dp;

  logic [3:0]           w_nib;
  logic                 w_dp_sel;
  logic                 w_blank_sel;
  logic [DIGITS-1:0]    w_onehot;
  logic [DIGITS-1:0]    w_lz;
  logic                 w_zero_run;
  logic                 w_lit;
  logic [6:0]           w_seg;

  function automatic logic [6:0] f_enc(input logic [3:0] n);
    case (n)
      4'h0: f_enc = 7'b0111111;
      4'h1: f_enc = 7'b0000110;
      4'h2: f_enc = 7'b1011011;
      4'h3: f_enc = 7'b1001111;
      4'h4: f_enc = 7'b1100110;
      4'h5: f_enc = 7'b1101101;
      4'h6: f_enc = 7'b1111101;
      4'h7: f_enc = 7'b0000111;
      4'h8: f_enc = 7'b1111111;
      4'h9: f_enc = 7'b1101111;
      4'hA: f_enc = 7'b1110111;
      4'hB: f_enc = 7'b1111100;
      4'hC: f_enc = 7'b0111001;
      4'hD: f_enc = 7'b1011110;
      4'hE: f_enc = 7'b1111001;
      default: f_enc = 7'b1110001;
    endcase
  endfunction

  // Shadow registers: written on any load, independent of enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_val <= '0;
      r_sh_dp  <= '0;
    end else if (i_load) begin
      r_sh_val <= i_value;
      r_sh_dp  <= i_dp_in;
    end
  end

  // Refresh divider and digit index; both freeze while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_enable) begin
      if (r_cnt == CW'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Leading-zero mask: scanning down from the top digit, a digit is blankable
  // while it and everything above it are zero. Digit 0 always shows.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_sh_val[4*i +: 4] == 4'h0);
      w_lz[i]    = (BLANK_LZ != 0) && (i != 0) && w_zero_run;
    end
  end

  // Select the scanned digit's nibble, dp, blank flag and anode bit.
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_sh_val[4*i +: 4];
        w_dp_sel    = r_sh_dp[i];
        w_blank_sel = w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // cnt == 0 is the anti-ghost gap: everything dark for that one clock.
  assign w_lit = i_enable && (r_cnt != '0);
  assign w_seg = (w_lit && !w_blank_sel) ? f_enc(w_nib) : 7'b0000000;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg_out   <= {7{SEG_INV}};
      o_dp_out    <= SEG_INV;
      o_anode     <= {DIGITS{AN_INV}};
      o_digit_idx <= 3'd0;
    end else begin
      o_seg_out   <= w_seg ^ {7{SEG_INV}};
      o_dp_out    <= (w_lit && w_dp_sel) ^ SEG_INV;
      o_anode     <= (w_lit ? w_onehot : '0) ^ {DIGITS{AN_INV}};
      o_digit_idx <= 3'(r_idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;

  logic [6:0] a_seg, b_seg, c_seg, d_seg;
  logic       a_dp, b_dp, c_dp, d_dp;
  logic [3:0] a_an, b_an, c_an;
  logic [0:0] d_an;
  logic [2:0] a_idx, b_idx, c_idx, d_idx;

  int total = 0;
  int bad = 0;
  int m_cnt, m_idx;

  always #5 clk = ~clk;

  // A: default polarity, blanking on.
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp_in(dp_in), .i_load(load), .i_enable(enable),
    .o_seg_out(a_seg), .o_dp_out(a_dp), .o_anode(a_an), .o_digit_idx(a_idx));
  // B: inverted polarities.
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp_in(dp_in), .i_load(load), .i_enable(enable),
    .o_seg_out(b_seg), .o_dp_out(b_dp), .o_anode(b_an), .o_digit_idx(b_idx));
  // C: blanking off.
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp_in(dp_in), .i_load(load), .i_enable(enable),
    .o_seg_out(c_seg), .o_dp_out(c_dp), .o_anode(c_an), .o_digit_idx(c_idx));
  // D: single digit.
  seven_seg_scanner #(.DIGITS(1), .REFRESH_DIV(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value[3:0]), .i_dp_in(dp_in[0]), .i_load(load), .i_enable(enable),
    .o_seg_out(d_seg), .o_dp_out(d_dp), .o_anode(d_an), .o_digit_idx(d_idx));

  // Reference scan position for the 4-digit, divide-by-4 instances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (enable) begin
      if (m_cnt == 3) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % 4;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Park at a negedge where the upcoming rising edge sees cnt=c, idx=d.
  task automatic wait_state(input int c, input int d);
    int n = 0;
    while (!(m_cnt == c && m_idx == d) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL wait_state cnt=%0d idx=%0d not reached (at cnt=%0d idx=%0d)", c, d, m_cnt, m_idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    tick(); tick();
    rst_n = 1'b1; enable = 1'b1;
    do_load(16'h12AF, 4'b0100);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (a_an !== 4'b1111 || a_seg !== 7'b0000000 || a_dp !== 1'b0 || a_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_a an=%b seg=%b dp=%b idx=%0d want an=1111 seg=0000000 dp=0 idx=0", a_an, a_seg, a_dp, a_idx);
    end
    total++;
    if (b_an !== 4'b0000 || b_seg !== 7'b1111111 || b_dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_b an=%b seg=%b dp=%b want an=0000 seg=1111111 dp=1", b_an, b_seg, b_dp);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (a_an !== 4'b1111) begin
      bad++; $display("FAIL reset_first_gap an=%b want 1111", a_an);
    end
    tick();
    total++;
    if (a_an !== 4'b1110 || a_idx !== 3'd0 || a_seg !== 7'b0111111) begin
      bad++; $display("FAIL reset_first_digit an=%b idx=%0d seg=%b want an=1110 idx=0 seg=0111111", a_an, a_idx, a_seg);
    end
  endtask

  task automatic test_full_scan();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    do_load(16'h12AF, 4'b0100);
    wait_state(0, 0);
    for (int k = 0; k < 16; k++) begin
      int d, p;
      d = k / 4; p = k % 4;
      tick();
      case (d)
        0: e_seg = 7'b1110001;
        1: e_seg = 7'b1110111;
        2: e_seg = 7'b1011011;
        default: e_seg = 7'b0000110;
      endcase
      e_an = ~(4'b0001 << d);
      if (p == 0) begin
        total++;
        if (a_an !== 4'b1111 || a_seg !== 7'b0 || a_dp !== 1'b0 || a_idx !== 3'(d)) begin
          bad++; $display("FAIL scan_gap k=%0d an=%b seg=%b dp=%b idx=%0d want an=1111 seg=0 dp=0 idx=%0d", k, a_an, a_seg, a_dp, a_idx, d);
        end
        total++;
        if (d_an !== 1'b1 || d_seg !== 7'b0) begin
          bad++; $display("FAIL scan1_gap k=%0d an=%b seg=%b want an=1 seg=0", k, d_an, d_seg);
        end
      end else begin
        total++;
        if (a_an !== e_an || a_seg !== e_seg || a_dp !== (d == 2) || a_idx !== 3'(d)) begin
          bad++; $display("FAIL scan_lit k=%0d an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%0d idx=%0d", k, a_an, a_seg, a_dp, a_idx, e_an, e_seg, (d == 2), d);
        end
        total++;
        if (d_an !== 1'b0 || d_seg !== 7'b1110001 || d_idx !== 3'd0) begin
          bad++; $display("FAIL scan1_lit k=%0d an=%b seg=%b idx=%0d want an=0 seg=1110001 idx=0", k, d_an, d_seg, d_idx);
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [6:0] ea [4];
    logic [6:0] ec [4];
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        do_load(16'h0050, 4'b0000);
        ea = '{7'b0111111, 7'b1101101, 7'b0000000, 7'b0000000};
        ec = '{7'b0111111, 7'b1101101, 7'b0111111, 7'b0111111};
      end else begin
        do_load(16'h0000, 4'b1000);
        ea = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
        ec = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      end
      wait_state(0, 0);
      for (int k = 0; k < 16; k++) begin
        int d;
        d = k / 4;
        tick();
        if (k % 4 == 2) begin
          total++;
          if (a_seg !== ea[d] || a_an !== ~(4'b0001 << d) || a_dp !== (t == 1 && d == 3)) begin
            bad++; $display("FAIL lz_blank t=%0d d=%0d seg=%b an=%b dp=%b want seg=%b dp=%0d", t, d, a_seg, a_an, a_dp, ea[d], (t == 1 && d == 3));
          end
          total++;
          if (c_seg !== ec[d]) begin
            bad++; $display("FAIL lz_noblank t=%0d d=%0d seg=%b want %b", t, d, c_seg, ec[d]);
          end
        end
      end
    end
  endtask

  task automatic test_polarity();
    do_load(16'h8888, 4'b0000);
    wait_state(0, 0);
    for (int k = 0; k < 16; k++) begin
      int d, p;
      d = k / 4; p = k % 4;
      tick();
      total++;
      if (p == 0) begin
        if (b_an !== 4'b0000 || b_seg !== 7'b1111111 || b_dp !== 1'b1) begin
          bad++; $display("FAIL pol_gap k=%0d an=%b seg=%b dp=%b want an=0000 seg=1111111 dp=1", k, b_an, b_seg, b_dp);
        end
      end else begin
        if (b_an !== (4'b0001 << d) || b_seg !== 7'b0000000 || b_dp !== 1'b1) begin
          bad++; $display("FAIL pol_lit k=%0d an=%b seg=%b dp=%b want an=%b seg=0000000 dp=1", k, b_an, b_seg, b_dp, 4'b0001 << d);
        end
      end
    end
  endtask

  task automatic test_enable();
    do_load(16'h12AF, 4'b0100);
    wait_state(2, 2);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (a_an !== 4'b1111 || a_seg !== 7'b0 || a_dp !== 1'b0 || a_idx !== 3'd2) begin
        bad++; $display("FAIL en_off k=%0d an=%b seg=%b dp=%b idx=%0d want an=1111 seg=0 dp=0 idx=2", k, a_an, a_seg, a_dp, a_idx);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (a_an !== 4'b1011 || a_seg !== 7'b1011011 || a_dp !== 1'b1 || a_idx !== 3'd2) begin
        bad++; $display("FAIL en_resume k=%0d an=%b seg=%b dp=%b idx=%0d want an=1011 seg=1011011 dp=1 idx=2", k, a_an, a_seg, a_dp, a_idx);
      end
    end
    tick();
    total++;
    if (a_an !== 4'b1111 || a_idx !== 3'd3) begin
      bad++; $display("FAIL en_gap an=%b idx=%0d want an=1111 idx=3", a_an, a_idx);
    end
  endtask

  task automatic test_load_collision();
    // Load on the first cycle of digit 0 (cnt just wrapped to 0).
    wait_state(0, 0);
    value = 16'h000F; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (a_an !== 4'b1111) begin
      bad++; $display("FAIL col_gap an=%b want 1111", a_an);
    end
    tick();
    total++;
    if (a_an !== 4'b1110 || a_seg !== 7'b1110001) begin
      bad++; $display("FAIL col_digit0 an=%b seg=%b want an=1110 seg=1110001", a_an, a_seg);
    end
    // Load on the very edge where the counter wraps from digit 3.
    wait_state(3, 3);
    value = 16'h000E; load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (a_an !== 4'b0111 || a_seg !== 7'b0000000) begin
      bad++; $display("FAIL wrap_d3 an=%b seg=%b want an=0111 seg=0000000", a_an, a_seg);
    end
    tick();
    total++;
    if (a_an !== 4'b1111 || a_idx !== 3'd0) begin
      bad++; $display("FAIL wrap_gap an=%b idx=%0d want an=1111 idx=0", a_an, a_idx);
    end
    tick();
    total++;
    if (a_an !== 4'b1110 || a_seg !== 7'b1111001) begin
      bad++; $display("FAIL wrap_new an=%b seg=%b want an=1110 seg=1111001", a_an, a_seg);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_leading_zeros();
    test_polarity();
    test_enable();
    test_load_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
